// File: rtl/counter_sequencer_pkg.sv
// Shared types for the counter sequencer: command modes, FSM states and the Gray encoder.
// The Gray path is only used when COUNTER_SEQ_GRAY_EN is defined.
package counter_seq_pkg;
  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_GRAY = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] gray_encode(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/counter_sequencer_if.sv
// Command channel into the counter sequencer (valid/ready handshake plus payload).
interface counter_sequencer_if #(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_load;
  logic [WIDTH-1:0]  cmd_load_val;

  modport master (output cmd_valid, cmd_mode, cmd_steps, cmd_load, cmd_load_val,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_mode, cmd_steps, cmd_load, cmd_load_val,
                  output cmd_ready);
endinterface

// File: rtl/counter_sequencer_core.sv
// Counter datapath: binary cnt register with preload and up/down step.
// wrap_next flags that the step taken on this edge rolls the counter over.
module counter_core #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             step,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap_next
);
  // dir=1 counts down; the rollover point differs by direction
  assign wrap_next = step && (dir ? (cnt == '0) : (cnt == '1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (step) cnt <= dir ? cnt - 1'b1 : cnt + 1'b1;
  end
endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for the counter datapath: accept, optional preload,
// N steps in the latched mode, done/wrap pulses. Gray output gated by COUNTER_SEQ_GRAY_EN.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  counter_sequencer_if.slave cmd,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);
  state_e            state, state_nxt;
  mode_e             mode_q, mode_in;
  logic [STEP_W-1:0] rem;
  logic [WIDTH-1:0]  cnt;
  logic              wrap_next, accept, do_step;

  assign accept  = cmd.cmd_valid && (state == ST_IDLE);
  // abort beats pause, and an exhausted rem never steps
  assign do_step = (state == ST_RUN) && !abort && (rem != '0) && !pause;

  always_comb begin
    mode_in = mode_e'(cmd.cmd_mode);
`ifndef COUNTER_SEQ_GRAY_EN
    if (mode_in == MODE_GRAY) mode_in = MODE_UP;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (abort || rem == '0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rem    <= '0;
      mode_q <= MODE_UP;
      wrap   <= 1'b0;
    end else begin
      wrap <= wrap_next;
      if (accept) begin
        rem    <= cmd.cmd_steps;
        mode_q <= mode_in;
      end else if (do_step) begin
        rem <= rem - 1'b1;
      end
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .step     (do_step && (mode_q != MODE_HOLD)),
    .dir      (mode_q == MODE_DOWN),
    .load     (accept && cmd.cmd_load),
    .load_val (cmd.cmd_load_val),
    .cnt      (cnt),
    .wrap_next(wrap_next)
  );

`ifdef COUNTER_SEQ_GRAY_EN
  assign Q = (mode_q == MODE_GRAY) ? WIDTH'(gray_encode(32'(cnt))) : cnt;
`else
  assign Q = cnt;
`endif

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: reset, each mode, pause/abort, zero-step command.
module tb_counter_sequencer;
  localparam int WIDTH  = 3;
  localparam int STEP_W = 8;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             pause, abort;
  logic [WIDTH-1:0] Q;
  logic             busy, done, wrap;
  int               checks = 0;
  int               errors = 0;

  counter_sequencer_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) cif ();

  counter_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .cmd  (cif.slave),
    .pause(pause),
    .abort(abort),
    .Q    (Q),
    .busy (busy),
    .done (done),
    .wrap (wrap)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // present a command for one edge (block is idle), leaving us just after the accept edge
  task automatic send(input logic [1:0] mode, input int steps, input logic ld, input int val);
    cif.cmd_valid    = 1'b1;
    cif.cmd_mode     = mode;
    cif.cmd_steps    = STEP_W'(steps);
    cif.cmd_load     = ld;
    cif.cmd_load_val = WIDTH'(val);
    tick();
    cif.cmd_valid    = 1'b0;
    cif.cmd_load     = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; pause = 1'b0; abort = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_mode = 2'd0; cif.cmd_steps = '0;
    cif.cmd_load = 1'b0; cif.cmd_load_val = '0;
    tick(); tick();
    chk("rst_q", 32'(Q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cif.cmd_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_wrap", 32'(wrap), 0);
    #2 RST_N = 1'b1;
    tick();

    // reset in the middle of an UP run
    send(2'd0, 5, 1'b0, 0);
    chk("r_busy0", 32'(busy), 1);
    tick(); chk("r_q1", 32'(Q), 1);
    tick(); chk("r_q2", 32'(Q), 2);
    #2 RST_N = 1'b0;
    #1;
    chk("r_mid_q", 32'(Q), 0);
    chk("r_mid_busy", 32'(busy), 0);
    chk("r_mid_ready", 32'(cif.cmd_ready), 1);
    chk("r_mid_done", 32'(done), 0);
    #3 RST_N = 1'b1;
    tick(); chk("r_after_done", 32'(done), 0);
    tick(); chk("r_after_idle", 32'(busy), 0);
    send(2'd0, 1, 1'b0, 0);
    tick(); chk("r_next_q", 32'(Q), 1);
    tick(); chk("r_next_done", 32'(done), 1);
    tick();

    // UP with preload 6, three steps through the rollover
    send(2'd0, 3, 1'b1, 6);
    chk("up_q0", 32'(Q), 6);
    chk("up_wrap0", 32'(wrap), 0);
    tick(); chk("up_q1", 32'(Q), 7);
    tick(); chk("up_q2", 32'(Q), 0); chk("up_wrap2", 32'(wrap), 1);
    tick(); chk("up_q3", 32'(Q), 1); chk("up_wrap3", 32'(wrap), 0); chk("up_done3", 32'(done), 0);
    tick(); chk("up_done4", 32'(done), 1); chk("up_busy4", 32'(busy), 1);
    tick(); chk("up_done5", 32'(done), 0); chk("up_ready5", 32'(cif.cmd_ready), 1);

    // DOWN from 1, two steps through 0 -> 7
    send(2'd1, 2, 1'b0, 0);
    chk("dn_q0", 32'(Q), 1);
    tick(); chk("dn_q1", 32'(Q), 0); chk("dn_wrap1", 32'(wrap), 0);
    tick(); chk("dn_q2", 32'(Q), 7); chk("dn_wrap2", 32'(wrap), 1);
    tick(); chk("dn_done", 32'(done), 1); chk("dn_wrap3", 32'(wrap), 0);
    tick(); chk("dn_idle", 32'(busy), 0);

    // GRAY from 0, four steps
    send(2'd2, 4, 1'b1, 0);
    chk("gr_q0", 32'(Q), 0);
`ifdef COUNTER_SEQ_GRAY_EN
    tick(); chk("gr_q1", 32'(Q), 1);
    tick(); chk("gr_q2", 32'(Q), 3);
    tick(); chk("gr_q3", 32'(Q), 2);
    tick(); chk("gr_q4", 32'(Q), 6);
`else
    tick(); chk("gr_q1", 32'(Q), 1);
    tick(); chk("gr_q2", 32'(Q), 2);
    tick(); chk("gr_q3", 32'(Q), 3);
    tick(); chk("gr_q4", 32'(Q), 4);
`endif
    tick(); chk("gr_done", 32'(done), 1);
    tick();

    // HOLD, three steps, paused for two cycles after the first; cnt is 4
    send(2'd3, 3, 1'b0, 0);
    chk("hd_q0", 32'(Q), 4);
    tick(); chk("hd_q1", 32'(Q), 4);
    pause = 1'b1;
    tick(); chk("hd_busy_p1", 32'(busy), 1);
    tick(); chk("hd_busy_p2", 32'(busy), 1);
    pause = 1'b0;
    tick(); chk("hd_done4", 32'(done), 0);
    tick(); chk("hd_done5", 32'(done), 0); chk("hd_q5", 32'(Q), 4);
    tick(); chk("hd_done6", 32'(done), 1); chk("hd_wrap6", 32'(wrap), 0);
    tick(); chk("hd_idle", 32'(busy), 0);

    // UP, ten steps, abort+pause together after step 2 (start cnt 4)
    send(2'd0, 10, 1'b0, 0);
    tick(); chk("ab_q1", 32'(Q), 5);
    tick(); chk("ab_q2", 32'(Q), 6);
    abort = 1'b1; pause = 1'b1;
    tick(); chk("ab_done", 32'(done), 1); chk("ab_q3", 32'(Q), 6);
    abort = 1'b0; pause = 1'b0;
    tick(); chk("ab_ready", 32'(cif.cmd_ready), 1); chk("ab_done_off", 32'(done), 0);

    // abort while idle is ignored; zero-step command still pulses done
    abort = 1'b1;
    tick(); chk("idle_abort", 32'(busy), 0);
    abort = 1'b0;
    send(2'd0, 0, 1'b0, 0);
    tick(); chk("z_done", 32'(done), 1); chk("z_q", 32'(Q), 6);
    tick(); chk("z_ready", 32'(cif.cmd_ready), 1);

    // preload applied even when aborted immediately
    abort = 1'b1;
    send(2'd0, 5, 1'b1, 2);
    chk("la_q", 32'(Q), 2);
    tick(); chk("la_done", 32'(done), 1); chk("la_q2", 32'(Q), 2);
    abort = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
